i3c_target_hdr_entry_rx: RTL and testbench
==========================================

// Module: i3c_target_hdr_entry_rx
// PURPOSE
//  Target-side SDR responder for the I3C controller's HDR entry sequence:
//  START, broadcast 7'h7E+W, ACK, ENTHDRx CCC byte plus T-bit.
//  Watches SCL/SDA, drives the ACK by pulling SDA low, and checks the T-bit.
//  Decodes the HDR mode and flags HDR entry to the target HDR engine.
//  Used as the bus-functional target in I3C_TOP system benches and as the
//  front end of the target RTL.
// PARAMETERS
//  SYNC_STAGES  2      flops in the SCL/SDA input synchronizers (min 2)
//  BCAST_ADDR   7'h7E  broadcast address that is ACKed
//  ENTHDR_BASE  8'h20  ENTHDR0 code; ENTHDRx = ENTHDR_BASE | x, x in 0..7
// PORTS
//  i_sdr_clk          in   1  system clock; all logic on rising edge
//  i_sdr_rst          in   1  synchronous reset, active-high
//  i_target_en        in   1  1: respond on bus; 0: force IDLE, SDA released
//  i_scl              in   1  SCL bus level (asynchronous)
//  i_sda              in   1  SDA bus level (asynchronous)
//  i_hdr_exit         in   1  pulse from HDR engine: HDR exit seen, return to IDLE
//  o_sda_pull_low     out  1  1: drive SDA low (open drain); 0: release
//  o_bcast_ack        out  1  1-clk pulse when the broadcast ACK is driven
//  o_hdr_enter        out  1  1-clk pulse on a valid ENTHDRx
//  o_hdr_active       out  1  held 1 from o_hdr_enter until i_hdr_exit or reset
//  o_hdr_mode         out  3  x of the last valid ENTHDRx (0 = HDR-DDR)
//  o_ccc_byte         out  8  last received CCC byte
//  o_parity_err       out  1  1-clk pulse: T-bit mismatch
//  o_ccc_unsupported  out  1  1-clk pulse: good parity, byte[7:3] != ENTHDR_BASE[7:3]
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, bit counter 0, synchronizers preset to 1.
//  Edge detection works on the synchronized scl_s/sda_s and their 1-clk delayed copies.
//   START/Sr = sda_s 1->0 while scl_s=1; STOP = sda_s 0->1 while scl_s=1.
//   Data bits are sampled on scl_s 0->1, MSB first.
//   Event latency = SYNC_STAGES+1 clocks after the pin change.
//  FSM states: IDLE, ADDR, ACK, CCC, CHECK, HDR, WAIT_STOP.
//   IDLE   : START -> ADDR; clear bit counter.
//   ADDR   : collect 8 bits. After 8th bit: {BCAST_ADDR,1'b0} -> ACK, else -> WAIT_STOP (NACK).
//   ACK    : on next scl_s fall assert o_sda_pull_low and pulse o_bcast_ack;
//            hold through the SCL high phase; release on the following scl_s fall -> CCC.
//   CCC    : collect 9 bits: byte[7:0], then T. Latch o_ccc_byte -> CHECK.
//   CHECK  : single clock. Expected T = ~^byte (odd parity).
//            Mismatch: pulse o_parity_err -> WAIT_STOP.
//            byte[7:3]==ENTHDR_BASE[7:3]: o_hdr_mode<=byte[2:0], pulse o_hdr_enter,
//            set o_hdr_active -> HDR.
//            Otherwise: pulse o_ccc_unsupported -> WAIT_STOP.
//   HDR    : ignore START/STOP; stay until i_hdr_exit -> IDLE, which clears o_hdr_active.
//   WAIT_STOP: SDA released; STOP -> IDLE; Sr -> ADDR.
//  Priority order in the same clock: i_sdr_rst, then !i_target_en, then STOP, then Sr, then bit sample.
//  STOP or Sr seen in ADDR/ACK/CCC aborts the frame; o_sda_pull_low is released in that same clock.
//  o_sda_pull_low is never 1 outside ACK, and is never asserted while scl_s=1 unless already held.
//  Deasserting i_target_en mid-frame: next clock IDLE, SDA released, o_hdr_active cleared.
//  Reset mid-ACK releases SDA on the next rising clock edge.
//  The bit counter is 4 bits and saturates; it never wraps into a false byte.
// TESTING
//  1. START, 0xFC, ACK slot, 0x20 with T=0 -> o_bcast_ack=1 at 9th SCL fall;
//     o_hdr_enter pulse, o_hdr_mode=0, o_hdr_active=1.
//  2. START, 0xFC, 0x21 with T=0 -> o_parity_err pulse; no o_hdr_enter; IDLE after STOP.
//  3. START, 0xA2 -> o_sda_pull_low stays 0 at the ACK slot (NACK); WAIT_STOP; IDLE after STOP.
//  4. START, 0xFC, 0x07 with T=0 -> o_ccc_unsupported pulse; o_ccc_byte=8'h07.
//  5. Sr during CCC bit 4 followed by a full 0xFC/0x26/T=0 sequence -> o_hdr_mode=6;
//     i_hdr_exit -> o_hdr_active=0, IDLE.
//  6. i_sdr_rst=1 while o_sda_pull_low=1 -> o_sda_pull_low=0 next clock; all outputs 0.

Source files
------------

// File: rtl/i3c_target_hdr_entry_rx.sv
// i3c_target_hdr_entry_rx: target-side SDR responder that ACKs the broadcast address and decodes ENTHDRx into HDR entry.
module i3c_target_hdr_entry_rx #(
  parameter int SYNC_STAGES = 2,
  parameter logic [6:0] BCAST_ADDR = 7'h7E,
  parameter logic [7:0] ENTHDR_BASE = 8'h20
) (
  input  logic       i_sdr_clk,
  input  logic       i_sdr_rst,
  input  logic       i_target_en,
  input  logic       i_scl,
  input  logic       i_sda,
  input  logic       i_hdr_exit,
  output logic       o_sda_pull_low,
  output logic       o_bcast_ack,
  output logic       o_hdr_enter,
  output logic       o_hdr_active,
  output logic [2:0] o_hdr_mode,
  output logic [7:0] o_ccc_byte,
  output logic       o_parity_err,
  output logic       o_ccc_unsupported
);
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  typedef enum logic [2:0] {IDLE, ADDR, ACK, CCC, CHECK, HDR, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [NS-1:0] scl_q, sda_q;
  logic scl_d, sda_d, scl_s, sda_s;
  logic rise, fall, start, stop, shift, bit_done, par_ok, supp, clr;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, ccc_n;
  logic tbit, tbit_n;
  logic pull_n, ack_n, enter_n, active_n, perr_n, unsup_n;
  logic [2:0] mode_n;
  always_ff @(posedge i_sdr_clk)
    if (i_sdr_rst) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= {scl_q[NS-2:0], i_scl};
      sda_q <= {sda_q[NS-2:0], i_sda};
      scl_d <= scl_q[NS-1];
      sda_d <= sda_q[NS-1];
    end
  assign scl_s = scl_q[NS-1];
  assign sda_s = sda_q[NS-1];
  assign rise = scl_s & ~scl_d;
  assign fall = ~scl_s & scl_d;
  assign start = scl_s & sda_d & ~sda_s;
  assign stop = scl_s & ~sda_d & sda_s;
  assign shift = rise && (state == ADDR || state == CCC);
  // address completes on the 8th sample, CCC on the 9th (byte plus T-bit)
  assign bit_done = rise && cnt == ((state == ADDR) ? 4'd7 : 4'd8);
  assign par_ok = tbit == ~^o_ccc_byte;
  assign supp = o_ccc_byte[7:3] == ENTHDR_BASE[7:3];
  always_ff @(posedge i_sdr_clk)
    if (i_sdr_rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (!i_target_en) state_n = IDLE;
    else
      case (state)
        IDLE:      state_n = start ? ADDR : IDLE;
        ADDR:      state_n = stop ? IDLE : start ? ADDR : !bit_done ? ADDR :
                             ({sh[6:0], sda_s} == {BCAST_ADDR, 1'b0}) ? ACK : WAIT_STOP;
        ACK:       state_n = stop ? IDLE : start ? ADDR : (fall && o_sda_pull_low) ? CCC : ACK;
        CCC:       state_n = stop ? IDLE : start ? ADDR : bit_done ? CHECK : CCC;
        CHECK:     state_n = (par_ok && supp) ? HDR : WAIT_STOP;
        HDR:       state_n = i_hdr_exit ? IDLE : HDR;
        WAIT_STOP: state_n = stop ? IDLE : start ? ADDR : WAIT_STOP;
        default:   state_n = IDLE;
      endcase
  end
  always_comb begin
    clr = start || (state == ACK && state_n == CCC);
    cnt_n = clr ? 4'd0 : (shift && cnt != 4'hF) ? cnt + 4'd1 : cnt;
    sh_n = shift ? {sh[6:0], sda_s} : sh;
    ccc_n = (state == CCC && state_n == CHECK) ? sh : o_ccc_byte;
    tbit_n = (state == CCC && state_n == CHECK) ? sda_s : tbit;
    // SDA is only ever grabbed on an SCL fall and dropped when ACK is left
    pull_n = state == ACK && state_n == ACK && (o_sda_pull_low || fall);
    ack_n = state == ACK && state_n == ACK && fall && !o_sda_pull_low;
    enter_n = state == CHECK && state_n == HDR;
    perr_n = state == CHECK && state_n == WAIT_STOP && !par_ok;
    unsup_n = state == CHECK && state_n == WAIT_STOP && par_ok;
    mode_n = enter_n ? o_ccc_byte[2:0] : o_hdr_mode;
    active_n = enter_n || (o_hdr_active && state_n == HDR);
  end
  always_ff @(posedge i_sdr_clk)
    if (i_sdr_rst) begin
      cnt <= '0;
      sh <= '0;
      tbit <= 1'b0;
      o_ccc_byte <= '0;
      o_sda_pull_low <= 1'b0;
      o_bcast_ack <= 1'b0;
      o_hdr_enter <= 1'b0;
      o_hdr_active <= 1'b0;
      o_hdr_mode <= '0;
      o_parity_err <= 1'b0;
      o_ccc_unsupported <= 1'b0;
    end else begin
      cnt <= cnt_n;
      sh <= sh_n;
      tbit <= tbit_n;
      o_ccc_byte <= ccc_n;
      o_sda_pull_low <= pull_n;
      o_bcast_ack <= ack_n;
      o_hdr_enter <= enter_n;
      o_hdr_active <= active_n;
      o_hdr_mode <= mode_n;
      o_parity_err <= perr_n;
      o_ccc_unsupported <= unsup_n;
    end
endmodule

// File: tb/tb_i3c_target_hdr_entry_rx.sv
// tb_i3c_target_hdr_entry_rx: bus-level stimulus with an event scoreboard for the HDR entry responder.
module tb_i3c_target_hdr_entry_rx;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, scl = 1'b1, sda_m = 1'b1, hdr_exit = 1'b0;
  logic pull, back, enter, active, perr, unsup, sda_bus, b;
  logic [2:0] mode;
  logic [7:0] ccc;
  logic [11:0] exp_q[$];
  int checks = 0, failures = 0;
  assign sda_bus = sda_m & ~pull;
  always #5 clk = ~clk;
  i3c_target_hdr_entry_rx dut (
    .i_sdr_clk(clk), .i_sdr_rst(rst), .i_target_en(en), .i_scl(scl), .i_sda(sda_bus),
    .i_hdr_exit(hdr_exit), .o_sda_pull_low(pull), .o_bcast_ack(back), .o_hdr_enter(enter),
    .o_hdr_active(active), .o_hdr_mode(mode), .o_ccc_byte(ccc), .o_parity_err(perr),
    .o_ccc_unsupported(unsup)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic sb_pop(input logic [11:0] got);
    if (exp_q.size() == 0) chk("sb_unexpected", got, 12'h0);
    else chk("sb_event", got, exp_q.pop_front());
  endtask
  always @(negedge clk) begin
    if (back) sb_pop({4'd1, 8'h00});
    if (enter) sb_pop({4'd2, ccc});
    if (perr) sb_pop({4'd3, ccc});
    if (unsup) sb_pop({4'd4, ccc});
  end
  function automatic logic [11:0] ccc_event(input logic [7:0] c, input logic t);
    if (t != ~^c) return {4'd3, c};
    return (c[7:3] == 5'b00100) ? {4'd2, c} : {4'd4, c};
  endfunction
  task automatic bus_start;
    sda_m = 1'b0; wclk(8); scl = 1'b0;
  endtask
  task automatic send_bit(input logic v);
    wclk(4); sda_m = v; wclk(4); scl = 1'b1; wclk(8); scl = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic read_bit(output logic v);
    wclk(4); sda_m = 1'b1; wclk(4); scl = 1'b1; wclk(4); v = sda_bus; wclk(4); scl = 1'b0;
  endtask
  task automatic rep_start;
    wclk(4); sda_m = 1'b1; wclk(4); scl = 1'b1; wclk(8); sda_m = 1'b0; wclk(8); scl = 1'b0;
  endtask
  task automatic bus_stop;
    wclk(4); sda_m = 1'b0; wclk(4); scl = 1'b1; wclk(8); sda_m = 1'b1; wclk(8);
  endtask
  task automatic hdr_seq(input logic [7:0] c, input logic t);
    logic a;
    send_byte(8'hFC);
    exp_q.push_back(12'h100);
    read_bit(a);
    chk("ack_slot", a, 1'b0);
    exp_q.push_back(ccc_event(c, t));
    send_byte(c);
    send_bit(t);
    wclk(4);
  endtask
  task automatic wait_pull;
    for (int i = 0; i < 20 && !pull; i++) wclk(1);
    chk("pull_seen", pull, 1'b1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    wclk(4);
    chk("reset_outputs", {pull, back, enter, active, mode, ccc, perr, unsup}, 0);
    rst = 1'b0;
    wclk(4);
    bus_start; hdr_seq(8'h20, 1'b0);
    chk("t1_mode", mode, 3'd0);
    chk("t1_active", active, 1'b1);
    chk("t1_ccc", ccc, 8'h20);
    bus_stop;
    chk("t1_hdr_ignores_stop", active, 1'b1);
    hdr_exit = 1'b1; wclk(1); hdr_exit = 1'b0; wclk(1);
    chk("t1_exit", active, 1'b0);
    bus_start; hdr_seq(8'h21, 1'b0);
    chk("t2_active", active, 1'b0);
    bus_stop;
    chk("t2_pull", pull, 1'b0);
    bus_start; send_byte(8'hA2); read_bit(b);
    chk("t3_nack", b, 1'b1);
    bus_stop;
    bus_start; hdr_seq(8'h07, 1'b0);
    chk("t4_ccc", ccc, 8'h07);
    chk("t4_active", active, 1'b0);
    bus_stop;
    bus_start; send_byte(8'hFC);
    exp_q.push_back(12'h100);
    read_bit(b);
    chk("t5_ack", b, 1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rep_start;
    chk("t5_ccc_kept", ccc, 8'h07);
    hdr_seq(8'h26, 1'b0);
    chk("t5_mode", mode, 3'd6);
    chk("t5_active", active, 1'b1);
    hdr_exit = 1'b1; wclk(1); hdr_exit = 1'b0; wclk(1);
    chk("t5_exit", active, 1'b0);
    bus_stop;
    bus_start; send_byte(8'hFC);
    exp_q.push_back(12'h100);
    wait_pull;
    rst = 1'b1; wclk(1);
    chk("t6_reset_release", pull, 1'b0);
    chk("t6_reset_outputs", {pull, back, enter, active, mode, ccc, perr, unsup}, 0);
    scl = 1'b1; sda_m = 1'b1; wclk(4); rst = 1'b0; wclk(10);
    bus_start; hdr_seq(8'h23, 1'b0);
    chk("t7_mode", mode, 3'd3);
    en = 1'b0; wclk(1);
    chk("t7_disable_active", active, 1'b0);
    en = 1'b1;
    bus_stop;
    bus_start; send_byte(8'hFC);
    exp_q.push_back(12'h100);
    wait_pull;
    en = 1'b0; wclk(1);
    chk("t7_disable_pull", pull, 1'b0);
    en = 1'b1;
    bus_stop;
    wclk(20);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
